// File: rtl/cnt_down_ctrl_pkg.sv
// Shared definitions for the countdown front-panel controller.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package cnt_down_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALRM  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] MMSS_D1_MAX = 4'd5;

  // One-hot digit strobe for a 2-bit digit index (digit0 -> 4'b0001).
  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    sel_onehot = 4'b0001 << sel;
  endfunction

  // Increment a BCD digit, wrapping to 0 once it has reached dmax.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] dmax);
    bcd_inc = (d >= dmax) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/cnt_down_ctrl_preset_reg.sv
// Preset store: four BCD digit registers plus the edit-selection pointer.
// Latency: digits/sel update on the edge after inc/next/clr; sel_nxt is the combinational next pointer.
// Backpressure: none; the caller only asserts inc or next when an edit is allowed.
module cnt_down_ctrl_preset_reg
  import cnt_down_ctrl_pkg::*;
#(
  parameter int MMSS = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  input  logic        next,
  output logic [15:0] digits,
  output logic [1:0]  sel,
  output logic [1:0]  sel_nxt
);

  // In mm:ss mode digit1 is the tens-of-seconds digit and stops at 5.
  logic [3:0] d1_max;
  assign d1_max  = (MMSS != 0) ? MMSS_D1_MAX : BCD_MAX;

  // The top registers the blink strobe from the pointer value that lands this edge.
  assign sel_nxt = clr  ? 2'd0 :
                   next ? sel + 2'd1 : sel;

  // Clear, advance the selection, or bump the selected digit with BCD wrap.
  always_ff @(posedge clk) begin
    if (clr) begin
      digits <= '0;
      sel    <= '0;
    end else begin
      sel <= sel_nxt;
      if (inc) begin
        case (sel)
          2'd0:    digits[3:0]   <= bcd_inc(digits[3:0],   BCD_MAX);
          2'd1:    digits[7:4]   <= bcd_inc(digits[7:4],   d1_max);
          2'd2:    digits[11:8]  <= bcd_inc(digits[11:8],  BCD_MAX);
          default: digits[15:12] <= bcd_inc(digits[15:12], BCD_MAX);
        endcase
      end
    end
  end

endmodule

// File: rtl/cnt_down_ctrl.sv
// Front-panel sequencer for the 4-digit BCD countdown chain: preset edit, start/pause, expiry, alarm.
// Latency: every output is registered; pulses appear one cycle after the causing input.
// Backpressure: none; same-cycle inputs resolve by priority RST > expiry > START > MODE > INC.
module cnt_down_ctrl
  import cnt_down_ctrl_pkg::*;
#(
  parameter int MMSS      = 1,
  parameter int ALARM_SEC = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TICK,
  input  logic        BTN_MODE,
  input  logic        BTN_INC,
  input  logic        BTN_START,
  input  logic [15:0] CNT_VAL,
  input  logic        CNT_BUSY,
  output logic [15:0] SET_VAL,
  output logic        RUN_TGL,
  output logic        CNT_DONE,
  output logic        ALARM,
  output logic [3:0]  DIGIT_BLINK,
  output logic [1:0]  STATE
);

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_SEC - 1);

  state_t     state;
  logic       phase;
  logic [7:0] alarm_cnt;
  logic [1:0] sel;
  logic [1:0] sel_nxt;
  logic       in_set;
  logic       do_next;
  logic       do_inc;
  logic       expired;
  logic       any_btn;

  // Preset edits happen only in SET, and only when no higher-priority button shares the cycle.
  assign in_set  = (state == ST_SET);
  assign do_next = in_set && BTN_MODE && !BTN_START;
  assign do_inc  = in_set && BTN_INC && !BTN_START && !BTN_MODE;
  assign expired = (state == ST_RUN) && CNT_BUSY && (CNT_VAL == 16'h0000);
  assign any_btn = BTN_START || BTN_MODE || BTN_INC;
  assign STATE   = state;

  cnt_down_ctrl_preset_reg #(
    .MMSS(MMSS)
  ) u_preset (
    .clk    (CLK),
    .clr    (RST),
    .inc    (do_inc),
    .next   (do_next),
    .digits (SET_VAL),
    .sel    (sel),
    .sel_nxt(sel_nxt)
  );

  // Controller FSM with registered pulses, blink phase and alarm timer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_SET;
      RUN_TGL     <= 1'b0;
      CNT_DONE    <= 1'b0;
      ALARM       <= 1'b0;
      phase       <= 1'b1;
      alarm_cnt   <= '0;
      DIGIT_BLINK <= 4'b0001;
    end else begin
      RUN_TGL  <= 1'b0;
      CNT_DONE <= 1'b0;
      case (state)
        ST_SET: begin
          if (BTN_START && (SET_VAL != 16'h0000)) begin
            RUN_TGL     <= 1'b1;
            state       <= ST_RUN;
            DIGIT_BLINK <= 4'b0000;
          end else if (TICK) begin
            phase       <= ~phase;
            DIGIT_BLINK <= phase ? 4'b0000 : sel_onehot(sel_nxt);
          end else begin
            DIGIT_BLINK <= phase ? sel_onehot(sel_nxt) : 4'b0000;
          end
        end
        ST_RUN: begin
          DIGIT_BLINK <= 4'b0000;
          if (expired) begin
            // Stop the chain and release its busy in one shot.
            RUN_TGL   <= 1'b1;
            CNT_DONE  <= 1'b1;
            ALARM     <= 1'b1;
            alarm_cnt <= '0;
            state     <= ST_ALRM;
          end else if (BTN_START) begin
            RUN_TGL <= 1'b1;
            state   <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          DIGIT_BLINK <= 4'b0000;
          if (BTN_START) begin
            RUN_TGL <= 1'b1;
            state   <= ST_RUN;
          end else if (BTN_MODE) begin
            // Cancel: chain is released, preset is kept for the next run.
            CNT_DONE    <= 1'b1;
            state       <= ST_SET;
            phase       <= 1'b1;
            DIGIT_BLINK <= sel_onehot(sel);
          end
        end
        ST_ALRM: begin
          DIGIT_BLINK <= 4'b0000;
          if (any_btn || (TICK && (alarm_cnt == ALARM_LAST))) begin
            ALARM       <= 1'b0;
            state       <= ST_SET;
            phase       <= 1'b1;
            DIGIT_BLINK <= sel_onehot(sel);
          end else if (TICK) begin
            alarm_cnt <= alarm_cnt + 8'd1;
          end
        end
        default: begin
          state       <= ST_SET;
          ALARM       <= 1'b0;
          phase       <= 1'b1;
          DIGIT_BLINK <= sel_onehot(sel);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_down_ctrl.sv
// Directed bench for cnt_down_ctrl with a cycle-tagged expectation queue and an independent monitor.
// Latency: expectations are tagged with the clock edge after which they must hold.
// Backpressure: n/a.
module tb_cnt_down_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, btn_mode, btn_inc, btn_start;
  logic [15:0] cnt_val;
  logic        cnt_busy;
  logic [15:0] set_val;
  logic        run_tgl, cnt_done, alarm;
  logic [3:0]  digit_blink;
  logic [1:0]  state;

  always #5 clk = ~clk;

  cnt_down_ctrl #(.MMSS(1), .ALARM_SEC(10)) dut (
    .CLK        (clk),
    .RST        (rst),
    .TICK       (tick),
    .BTN_MODE   (btn_mode),
    .BTN_INC    (btn_inc),
    .BTN_START  (btn_start),
    .CNT_VAL    (cnt_val),
    .CNT_BUSY   (cnt_busy),
    .SET_VAL    (set_val),
    .RUN_TGL    (run_tgl),
    .CNT_DONE   (cnt_done),
    .ALARM      (alarm),
    .DIGIT_BLINK(digit_blink),
    .STATE      (state)
  );

  // mask bits: [4] state, [3] set_val, [2] run_tgl+cnt_done, [1] alarm, [0] digit_blink
  localparam logic [4:0] M_ALL = 5'b11111;
  localparam logic [4:0] M_BLK = 5'b00001;
  localparam logic [4:0] M_VAL = 5'b01000;
  localparam logic [4:0] M_SVP = 5'b11100;
  localparam logic [4:0] M_SP  = 5'b10100;
  localparam logic [4:0] M_SPA = 5'b10110;

  typedef struct {
    string       name;
    int          cyc;
    logic [4:0]  m;
    logic [1:0]  st;
    logic [15:0] val;
    logic        tgl;
    logic        done;
    logic        alm;
    logic [3:0]  blk;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   bad;

  // Apply one cycle of button inputs; returns at the falling edge so expectations can follow.
  task automatic step(input logic t, input logic m, input logic i, input logic s);
    @(negedge clk);
    tick      = t;
    btn_mode  = m;
    btn_inc   = i;
    btn_start = s;
  endtask

  task automatic expect_out(input string name, input logic [4:0] m, input logic [1:0] st,
                            input logic [15:0] val, input logic tgl, input logic done,
                            input logic alm, input logic [3:0] blk);
    exp_t x;
    x.name = name; x.cyc = cyc + 1; x.m = m; x.st = st; x.val = val;
    x.tgl = tgl; x.done = done; x.alm = alm; x.blk = blk;
    q.push_back(x);
  endtask

  // Monitor: after each rising edge, check every expectation due at this edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      bad = (e.cyc != cyc);
      if (e.m[4] && state       !== e.st)  bad = 1'b1;
      if (e.m[3] && set_val     !== e.val) bad = 1'b1;
      if (e.m[2] && (run_tgl !== e.tgl || cnt_done !== e.done)) bad = 1'b1;
      if (e.m[1] && alarm       !== e.alm) bad = 1'b1;
      if (e.m[0] && digit_blink !== e.blk) bad = 1'b1;
      n_cmp = n_cmp + 1;
      if (bad) begin
        n_bad = n_bad + 1;
        $display("FAIL %s @cyc %0d mask=%b: got st=%0d val=%h tgl=%b done=%b alm=%b blk=%b; want st=%0d val=%h tgl=%b done=%b alm=%b blk=%b",
                 e.name, cyc, e.m, state, set_val, run_tgl, cnt_done, alarm, digit_blink,
                 e.st, e.val, e.tgl, e.done, e.alm, e.blk);
      end
    end
  end

  initial begin
    rst = 1'b1; tick = 0; btn_mode = 0; btn_inc = 0; btn_start = 0;
    cnt_val = 16'h0000; cnt_busy = 1'b0;

    // Reset state
    step(0, 0, 0, 0); expect_out("reset",        M_ALL, 2'd0, 16'h0000, 0, 0, 0, 4'b0001);
    step(0, 0, 0, 0); rst = 1'b0;
    expect_out("idle_after_rst", M_ALL, 2'd0, 16'h0000, 0, 0, 0, 4'b0001);

    // 1: select digit3, set it to 2, blink follows TICK
    step(0, 1, 0, 0); expect_out("t1_mode1", M_BLK, 2'd0, 16'h0000, 0, 0, 0, 4'b0010);
    step(0, 1, 0, 0); expect_out("t1_mode2", M_BLK, 2'd0, 16'h0000, 0, 0, 0, 4'b0100);
    step(0, 1, 0, 0); expect_out("t1_mode3", M_BLK, 2'd0, 16'h0000, 0, 0, 0, 4'b1000);
    step(0, 0, 1, 0); expect_out("t1_inc1",  M_VAL, 2'd0, 16'h1000, 0, 0, 0, 4'b0000);
    step(0, 0, 1, 0); expect_out("t1_val2000", M_ALL, 2'd0, 16'h2000, 0, 0, 0, 4'b1000);
    step(1, 0, 0, 0); expect_out("t1_tick_off", M_BLK, 2'd0, 16'h0000, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 0); expect_out("t1_hold_off", M_BLK, 2'd0, 16'h0000, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0); expect_out("t1_tick_on",  M_BLK, 2'd0, 16'h0000, 0, 0, 0, 4'b1000);

    // 2: mm:ss wrap of digit1, START with zero preset ignored
    step(0, 0, 0, 0); rst = 1'b1;
    expect_out("t2_reset", M_ALL, 2'd0, 16'h0000, 0, 0, 0, 4'b0001);
    step(0, 0, 0, 0); rst = 1'b0;
    step(0, 1, 0, 0); expect_out("t2_sel_d1", M_BLK, 2'd0, 16'h0000, 0, 0, 0, 4'b0010);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 1, 0);
      expect_out($sformatf("t2_inc%0d", k), M_VAL, 2'd0, 16'((k % 6) * 16), 0, 0, 0, 4'b0000);
    end
    step(0, 0, 0, 1); expect_out("t2_start_ignored", M_SVP, 2'd0, 16'h0000, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 0); expect_out("t2_still_set",     M_SP,  2'd0, 16'h0000, 0, 0, 0, 4'b0000);

    // 3: preset 3, run to expiry, alarm for 10 ticks, preset retained
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    step(0, 0, 1, 0); expect_out("t3_val3", M_VAL, 2'd0, 16'h0003, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 1); expect_out("t3_start", M_ALL, 2'd1, 16'h0003, 1, 0, 0, 4'b0000);
    step(0, 0, 0, 0); cnt_busy = 1'b1; cnt_val = 16'h0003;
    expect_out("t3_pulse_end", M_ALL, 2'd1, 16'h0003, 0, 0, 0, 4'b0000);
    step(1, 0, 1, 0); cnt_val = 16'h0002;
    expect_out("t3_inc_in_run", M_SVP, 2'd1, 16'h0003, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0); cnt_val = 16'h0001;
    step(1, 0, 0, 0); cnt_val = 16'h0000;
    expect_out("t3_expiry", M_ALL, 2'd3, 16'h0003, 1, 1, 1, 4'b0000);
    step(0, 0, 0, 0); cnt_busy = 1'b0;
    expect_out("t3_alarm_on", M_ALL, 2'd3, 16'h0003, 0, 0, 1, 4'b0000);
    for (int k = 1; k <= 10; k++) begin
      step(1, 0, 0, 0);
      if (k < 10) expect_out($sformatf("t3_alarm_tick%0d", k), M_SPA, 2'd3, 16'h0003, 0, 0, 1, 4'b0000);
      else        expect_out("t3_alarm_end", M_ALL, 2'd0, 16'h0003, 0, 0, 0, 4'b0001);
    end

    // 4: pause, edits ignored in RUN/PAUSE, MODE cancels
    step(0, 0, 0, 1); cnt_busy = 1'b1; cnt_val = 16'h0003;
    expect_out("t4_start", M_ALL, 2'd1, 16'h0003, 1, 0, 0, 4'b0000);
    step(0, 0, 1, 0); expect_out("t4_inc_run",   M_SVP, 2'd1, 16'h0003, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 1); expect_out("t4_pause",     M_ALL, 2'd2, 16'h0003, 1, 0, 0, 4'b0000);
    step(0, 0, 1, 0); expect_out("t4_inc_pause", M_SVP, 2'd2, 16'h0003, 0, 0, 0, 4'b0000);
    step(0, 1, 0, 0); expect_out("t4_cancel",    M_ALL, 2'd0, 16'h0003, 0, 1, 0, 4'b0001);
    step(0, 0, 0, 0); cnt_busy = 1'b0;
    expect_out("t4_done_end", M_SVP, 2'd0, 16'h0003, 0, 0, 0, 4'b0000);

    // 5: expiry beats START; a button silences the alarm without editing
    step(0, 0, 0, 1); expect_out("t5_start", M_ALL, 2'd1, 16'h0003, 1, 0, 0, 4'b0000);
    step(0, 0, 0, 1); cnt_busy = 1'b1; cnt_val = 16'h0000;
    expect_out("t5_expiry_vs_start", M_ALL, 2'd3, 16'h0003, 1, 1, 1, 4'b0000);
    step(0, 0, 0, 0); cnt_busy = 1'b0;
    expect_out("t5_single_tgl", M_SPA, 2'd3, 16'h0003, 0, 0, 1, 4'b0000);
    step(0, 0, 1, 0); expect_out("t5_inc_silences", M_ALL, 2'd0, 16'h0003, 0, 0, 0, 4'b0001);
    step(0, 0, 0, 0); expect_out("t5_val_kept",     M_SVP, 2'd0, 16'h0003, 0, 0, 0, 4'b0000);

    // 6: reset in RUN and in ALRM
    step(0, 0, 0, 1); expect_out("t6_start", M_SP, 2'd1, 16'h0003, 1, 0, 0, 4'b0000);
    step(0, 0, 0, 0); cnt_busy = 1'b1; cnt_val = 16'h0003;
    step(0, 0, 0, 0); rst = 1'b1;
    expect_out("t6_rst_run", M_ALL, 2'd0, 16'h0000, 0, 0, 0, 4'b0001);
    step(0, 0, 0, 0); rst = 1'b0; cnt_busy = 1'b0; cnt_val = 16'h0000;
    expect_out("t6_no_pulse", M_ALL, 2'd0, 16'h0000, 0, 0, 0, 4'b0001);
    step(0, 0, 1, 0); expect_out("t6_val1",  M_VAL, 2'd0, 16'h0001, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 1); expect_out("t6_start2", M_SP, 2'd1, 16'h0001, 1, 0, 0, 4'b0000);
    step(0, 0, 0, 0); cnt_busy = 1'b1; cnt_val = 16'h0000;
    expect_out("t6_expiry", M_ALL, 2'd3, 16'h0001, 1, 1, 1, 4'b0000);
    step(0, 0, 0, 0); cnt_busy = 1'b0; rst = 1'b1;
    expect_out("t6_rst_alrm", M_ALL, 2'd0, 16'h0000, 0, 0, 0, 4'b0001);
    step(0, 0, 0, 0); rst = 1'b0;
    expect_out("t6_no_pulse2", M_ALL, 2'd0, 16'h0000, 0, 0, 0, 4'b0001);

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    n_cmp = n_cmp + 1;
    if (q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
